mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter that shares the single unified memory port (data RAM below the RAM/ROM boundary, ROM above it) between the CPU (master 0) and a secondary reader/writer such as a display or DMA engine (master 1).
- Each access is serialised through a 3-state FSM with registered memory-side outputs.
- Priority is fixed to master 0, with a starvation guard for master 1.
- Writes into the ROM region are blocked and flagged as errors.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- RAM_TOP, 1020, highest byte address in the RAM region; addresses above it are ROM (read-only).
- STARVE_LIMIT, 4, consecutive lost arbitrations after which master 1 is forced to win.
- CW, 3, width of the starvation counter; must satisfy 2^CW > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous active-high reset.
- m0_req  in  1  master 0 access request; level-held until m0_gnt.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  AW  master 0 byte address.
- m0_wd  in  DW  master 0 write data.
- m0_gnt  out  1  one-cycle pulse: master 0 request accepted.
- m0_done  out  1  one-cycle pulse: master 0 access complete, m0_rd valid.
- m0_err  out  1  valid with m0_done: write to ROM region or misaligned address.
- m0_rd  out  DW  master 0 read data, held until the next master 0 done.
- m1_req, m1_we, m1_addr, m1_wd, m1_gnt, m1_done, m1_err, m1_rd: same as the master 0 ports, for master 1.
- mem_we  out  1  memory write enable.
- mem_a  out  AW  memory byte address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data; combinational read of mem_a.
- grant_cnt0  out  16  master 0 completed-access count (see Optional Feature).
- grant_cnt1  out  16  master 1 completed-access count.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset; all state changes on the rising edge of clk.
- Reset values: state=IDLE; mN_gnt, mN_done, mN_err = 0; mN_rd = 0; mem_we = 0; mem_a = 0; mem_wd = 0; starvation counter = 0; grant counters = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, on a clock edge where any mN_req is high:
  - pick a winner;
  - latch we, addr and wd from the winner into mem_we/mem_a/mem_wd;
  - pulse the winner's gnt in the next cycle;
  - go to ISSUE.
  - With no request, stay in IDLE with mem_we=0.
- ISSUE (exactly 1 cycle):
  - mem_a and mem_wd are held stable.
  - mem_we is high only if the latched we=1, the address is RAM (addr <= RAM_TOP) and addr[1:0]==0; otherwise mem_we=0 and the err flag is latched.
  - The memory write commits on the edge that ends ISSUE.
  - mem_rd is captured into the winner's rd register on that same edge (reads also use the captured value on write cycles).
  - Go to RESP.
- RESP (1 cycle): winner's done=1; err=1 if flagged. mem_we=0. Go to IDLE.
- Latency and throughput:
  - req sampled at edge t; gnt high in cycle t+1 (ISSUE); done high in cycle t+2 (RESP).
  - Back in IDLE at cycle t+3, so one access per 3 cycles.
- Requester handshake:
  - Must hold req/we/addr/wd until gnt.
  - May drop req in the gnt cycle. req still high in IDLE is treated as a new request.
- Arbitration:
  - Master 0 wins ties unless the starvation counter equals STARVE_LIMIT, in which case master 1 wins.
  - Counter increments when master 1 requests and loses; it clears when master 1 wins or m1_req is low in IDLE.
  - Saturating, never exceeds STARVE_LIMIT.
- Only one master's gnt, done or err is ever high in a cycle.
- Reset mid-operation:
  - A write whose ISSUE edge coincides with reset still commits in memory.
  - No done is issued. All outputs return to reset values on that edge.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- Defined: grant_cnt0/grant_cnt1 increment on each mN_done pulse (16-bit, wrap at 65535->0) and clear on reset.
- Undefined: no counter flops; grant_cnt0/grant_cnt1 are tied to 0.
- Ports are present either way.

Test Plan:
- m0 read of addr 8 with RAM[2]=0xDEADBEEF, req at edge 0 -> m0_gnt in cycle 1, m0_done in cycle 2, m0_rd=0xDEADBEEF, m0_err=0.
- m1 write 0x12345678 to addr 16, then m1 read of addr 16 -> mem_we high only during ISSUE; read returns 0x12345678, err=0.
- m0 write to addr 1028 (ROM) -> mem_we stays 0, m0_done with m0_err=1; ROM contents unchanged.
- m0 and m1 both request continuously, STARVE_LIMIT=4 -> grant order m0,m0,m0,m0,m1, repeating; never two gnts in one cycle.
- Reset asserted during ISSUE of an m1 write to addr 4 -> RAM[1] updated, no m1_done, all outputs 0 next cycle, state IDLE.
- MEM_ARB_STATS_EN defined, 3 m0 accesses and 2 m1 accesses -> grant_cnt0=3, grant_cnt1=2; undefined -> both read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-master arbiter (fixed m0 priority, m1 starvation guard) for a
//            unified RAM/ROM port; optional grant counters via MEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RAM_TOP      = 1020,
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic          m0_err,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic          m1_err,
    output logic [DW-1:0] m1_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [AW-1:0] C_RAM_TOP    = AW'(RAM_TOP);

    state_t        state_q;
    logic          sel_q;
    logic          err_pend_q;
    logic [CW-1:0] starve_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_a_q;
    logic [DW-1:0] mem_wd_q;
    logic          gnt0_q, gnt1_q;
    logic          done0_q, done1_q;
    logic          err0_q, err1_q;
    logic [DW-1:0] rd0_q, rd1_q;

    logic          w_any_req;
    logic          w_m1_wins;
    logic          w_win_we;
    logic [AW-1:0] w_win_addr;
    logic [DW-1:0] w_win_wd;
    logic          w_in_ram;
    logic          w_aligned;

    // m1 wins when alone, or when it has lost STARVE_LIMIT arbitrations in a row
    assign w_any_req  = m0_req | m1_req;
    assign w_m1_wins  = m1_req && (!m0_req || (starve_q == C_STARVE_MAX));
    assign w_win_we   = w_m1_wins ? m1_we   : m0_we;
    assign w_win_addr = w_m1_wins ? m1_addr : m0_addr;
    assign w_win_wd   = w_m1_wins ? m1_wd   : m0_wd;
    assign w_in_ram   = (w_win_addr <= C_RAM_TOP);
    assign w_aligned  = (w_win_addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            err_pend_q <= 1'b0;
            starve_q   <= '0;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    mem_we_q <= 1'b0;
                    if (!m1_req || w_m1_wins) begin
                        starve_q <= '0;
                    end else if (starve_q != C_STARVE_MAX) begin
                        starve_q <= starve_q + CW'(1);
                    end
                    if (w_any_req) begin
                        sel_q      <= w_m1_wins;
                        mem_a_q    <= w_win_addr;
                        mem_wd_q   <= w_win_wd;
                        // ROM writes and misaligned accesses never reach the memory
                        mem_we_q   <= w_win_we && w_in_ram && w_aligned;
                        err_pend_q <= (w_win_we && !w_in_ram) || !w_aligned;
                        gnt0_q     <= !w_m1_wins;
                        gnt1_q     <= w_m1_wins;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_we_q <= 1'b0;
                    if (sel_q) begin
                        rd1_q   <= mem_rd;
                        done1_q <= 1'b1;
                        err1_q  <= err_pend_q;
                    end else begin
                        rd0_q   <= mem_rd;
                        done0_q <= 1'b1;
                        err0_q  <= err_pend_q;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Counts advance on the same edge that raises the corresponding done
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (state_q == S_ISSUE) begin
            if (sel_q) begin
                cnt1_q <= cnt1_q + 16'd1;
            end else begin
                cnt0_q <= cnt0_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

    assign m0_gnt  = gnt0_q;
    assign m1_gnt  = gnt1_q;
    assign m0_done = done0_q;
    assign m1_done = done1_q;
    assign m0_err  = err0_q;
    assign m1_err  = err1_q;
    assign m0_rd   = rd0_q;
    assign m1_rd   = rd1_q;
    assign mem_we  = mem_we_q;
    assign mem_a   = mem_a_q;
    assign mem_wd  = mem_wd_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [15:0] grant_cnt0, grant_cnt1;

    logic [31:0] ram [0:511];
    logic        bd_we;
    logic [8:0]  bd_idx;
    logic [31:0] bd_data;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wd      (m0_wd),
        .m0_gnt     (m0_gnt),
        .m0_done    (m0_done),
        .m0_err     (m0_err),
        .m0_rd      (m0_rd),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wd      (m1_wd),
        .m1_gnt     (m1_gnt),
        .m1_done    (m1_done),
        .m1_err     (m1_err),
        .m1_rd      (m1_rd),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    // Word-addressed RAM model; bench preloads go through the bd_* port
    assign mem_rd = ram[mem_a[10:2]];
    always @(posedge clk) begin
        if (mem_we) ram[mem_a[10:2]] <= mem_wd;
        else if (bd_we) ram[bd_idx] <= bd_data;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [8:0] idx, input logic [31:0] data);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic drive(input bit m, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd;
        end
    endtask

    // One access by a lone requester: gnt one cycle after the sampling edge, done one later
    task automatic run_access(input bit m, input bit we, input logic [31:0] addr,
                              input logic [31:0] wd, input string tag,
                              input bit exp_mwe, input bit exp_err,
                              input bit chk_rd, input logic [31:0] exp_rd);
        int lat = 0;
        bit seen = 1'b0;
        drive(m, 1'b1, we, addr, wd);
        while (!seen && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            seen = m ? m1_gnt : m0_gnt;
        end
        if (!seen) begin
            check_val({tag, "_gnt_timeout"}, 32'(seen), 32'd1);
            drive(m, 1'b0, 1'b0, 32'd0, 32'd0);
            return;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd1);
        check_val({tag, "_issue_we"}, 32'(mem_we), 32'(exp_mwe));
        check_val({tag, "_other_gnt"}, 32'(m ? m0_gnt : m1_gnt), 32'd0);
        drive(m, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_val({tag, "_done"}, 32'(m ? m1_done : m0_done), 32'd1);
        check_val({tag, "_err"}, 32'(m ? m1_err : m0_err), 32'(exp_err));
        check_val({tag, "_other_done"}, 32'(m ? m0_done : m1_done), 32'd0);
        check_val({tag, "_resp_we"}, 32'(mem_we), 32'd0);
        if (chk_rd) check_val({tag, "_rd"}, m ? m1_rd : m0_rd, exp_rd);
        @(posedge clk); #1;
        check_val({tag, "_done_end"}, 32'(m ? m1_done : m0_done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_gnt"}, 32'({m0_gnt, m1_gnt}), 32'd0);
        check_val({tag, "_done"}, 32'({m0_done, m1_done}), 32'd0);
        check_val({tag, "_err"}, 32'({m0_err, m1_err}), 32'd0);
        check_val({tag, "_m0_rd"}, m0_rd, 32'd0);
        check_val({tag, "_m1_rd"}, m1_rd, 32'd0);
        check_val({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_val({tag, "_mem_a"}, mem_a, 32'd0);
        check_val({tag, "_mem_wd"}, mem_wd, 32'd0);
        check_val({tag, "_cnts"}, {grant_cnt0, grant_cnt1}, 32'd0);
    endtask

    initial begin
        int got_n;
        int cyc;
        reset = 1'b1;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        preload(9'd2,   32'hDEADBEEF);
        preload(9'd4,   32'hAAAA5555);
        preload(9'd5,   32'h55AA55AA);
        preload(9'd257, 32'hC0DEC0DE);
        preload(9'd1,   32'h00000000);
        reset = 1'b0;
        @(posedge clk); #1;

        run_access(1'b0, 1'b0, 32'd8,  32'd0, "m0_rd8", 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        run_access(1'b1, 1'b1, 32'd16, 32'h12345678, "m1_wr16", 1'b1, 1'b0, 1'b1, 32'hAAAA5555);
        run_access(1'b1, 1'b0, 32'd16, 32'd0, "m1_rd16", 1'b0, 1'b0, 1'b1, 32'h12345678);
        run_access(1'b0, 1'b1, 32'd1028, 32'hFFFFFFFF, "m0_wr_rom", 1'b0, 1'b1, 1'b1, 32'hC0DEC0DE);
        check_val("rom_intact", ram[257], 32'hC0DEC0DE);
        run_access(1'b0, 1'b1, 32'd1020, 32'h0F0F0F0F, "m0_wr_top", 1'b1, 1'b0, 1'b0, 32'd0);
        check_val("ram_top_written", ram[255], 32'h0F0F0F0F);
        run_access(1'b0, 1'b1, 32'd1024, 32'h0F0F0F0F, "m0_wr_rom0", 1'b0, 1'b1, 1'b0, 32'd0);
        run_access(1'b1, 1'b0, 32'd18, 32'd0, "m1_rd_mis", 1'b0, 1'b1, 1'b1, 32'h12345678);
        run_access(1'b0, 1'b1, 32'd22, 32'h11111111, "m0_wr_mis", 1'b0, 1'b1, 1'b0, 32'd0);
        check_val("mis_wr_blocked", ram[5], 32'h55AA55AA);

        // Both masters hold requests: four m0 grants, then one forced m1 grant
        drive(1'b0, 1'b1, 1'b0, 32'd8, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd16, 32'd0);
        got_n = 0;
        cyc = 0;
        while (got_n < 10 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            check_val("one_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
            check_val("one_done", 32'(m0_done & m1_done), 32'd0);
            if (m0_gnt || m1_gnt) begin
                check_val($sformatf("order%0d", got_n), 32'(m1_gnt), 32'((got_n % 5) == 4));
                got_n++;
            end
        end
        check_val("order_count", 32'(got_n), 32'd10);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset lands on the edge that ends ISSUE of an m1 write
        drive(1'b1, 1'b1, 1'b1, 32'd4, 32'hCAFEF00D);
        @(posedge clk); #1;
        check_val("rst_wr_gnt", 32'(m1_gnt), 32'd1);
        check_val("rst_wr_we", 32'(mem_we), 32'd1);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        check_val("rst_wr_commit", ram[1], 32'hCAFEF00D);
        check_all_zero("rst_mid");
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("rst_no_done", 32'({m0_done, m1_done}), 32'd0);

        run_access(1'b0, 1'b0, 32'd8,  32'd0, "st_a", 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 32'd16, 32'd0, "st_b", 1'b0, 1'b0, 1'b1, 32'h12345678);
        run_access(1'b0, 1'b0, 32'd8,  32'd0, "st_c", 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 32'd4,  32'd0, "st_d", 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        run_access(1'b0, 1'b0, 32'd8,  32'd0, "st_e", 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
`ifdef MEM_ARB_STATS_EN
        check_val("grant_cnt0", 32'(grant_cnt0), 32'd3);
        check_val("grant_cnt1", 32'(grant_cnt1), 32'd2);
`else
        check_val("grant_cnt0", 32'(grant_cnt0), 32'd0);
        check_val("grant_cnt1", 32'(grant_cnt1), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
